uart_word_tx: RTL and testbench
===============================

Name: uart_word_tx

Overview:
- Transmit side of the Sigma Delta DAQ UART link; consumes the tx modport signals of UartInterface (data, valid, ready, sig).
- Accepts one DATA_LENGTH-bit word through a valid/ready handshake.
- Splits the word into bytes and serializes each as a standard UART frame on sig.
- Sits between the UartManager (tx_writer side) and the board TX pin; the matching receiver consumes sig through the rx modport.

Parameters:
- DATA_LENGTH, 48, word width in bits; must be a multiple of 8 (elaboration error otherwise).
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 2.
- PARITY_EN, 1, 1 inserts an even-parity bit after the data bits; 0 omits it.
- STOP_BITS, 1, number of stop bits per frame (1 or 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data  input  DATA_LENGTH  word to transmit; sampled only on handshake.
- valid  input  1  writer has a word on data.
- ready  output  1  block can accept a word this cycle.
- sig  output  1  serial UART line, idle high.
- busy  output  1  high from handshake until the last stop bit of the last byte ends.

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous and active-high (reset).
- Reset values (reset sampled high): sig=1, ready=0, busy=0, state=IDLE, all counters 0. ready goes to 1 the first cycle after reset deasserts.
- Handshake: a transfer occurs on a rising edge where valid=1 and ready=1.
  - data is captured into the shift register on that edge.
  - ready=0 and busy=1 from the next cycle.
  - valid while ready=0 is ignored; data changes while busy have no effect.
- Byte order: most-significant byte first (data[DATA_LENGTH-1 -: 8]), then descending; NBYTES = DATA_LENGTH/8.
- Bit order within a byte: LSB first.
- Frame per byte: start (0), D0..D7, parity (if PARITY_EN), STOP_BITS stop bits (1).
  - Parity is even: XOR of the 8 data bits, so the total count of ones including parity is even.
- Bit timing: each bit is held on sig for exactly CLKS_PER_BIT cycles. A baud counter runs 0..CLKS_PER_BIT-1 and advances the bit on terminal count.
- Latency: the start bit of byte 0 appears on sig the cycle after the handshake edge.
- Back-to-back bytes: the next start bit immediately follows the last stop bit of the previous byte; no idle gap inside a word.
- Word duration: NBYTES*(10+PARITY_EN+STOP_BITS-1)*CLKS_PER_BIT cycles; 66*CLKS_PER_BIT with the defaults.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on handshake.
  - START -> DATA after one bit period.
  - DATA -> PARITY (PARITY_EN=1) or STOP after the 8th bit period.
  - PARITY -> STOP after one bit period.
  - STOP -> START when stop bits are done and bytes remain (byte counter increments).
  - STOP -> IDLE when stop bits are done and the last byte is sent.
- End of word: on entry to IDLE, ready=1 and busy=0 in the same cycle.
  - A handshake in that first IDLE cycle is legal.
  - The next start bit then follows immediately, so the line is idle for 1 bit-time-equivalent only through the stop bit(s).
- Reset mid-frame: aborts on that edge. sig=1 and busy=0 on the next cycle; the partial word is dropped and never resumed.
- Reset and valid high on the same edge: reset wins; no capture.
- Registers: sig is driven from a register (glitch-free); no combinational path from inputs to sig. ready is a registered function of state.

Test Plan:
- Reset check (CLKS_PER_BIT=4): hold reset 3 cycles with valid=1 -> sig=1, ready=0, busy=0 throughout; ready=1 the first cycle after release; no transfer occurs.
- Single word (CLKS_PER_BIT=4, PARITY_EN=1, STOP_BITS=1): send data=48'h123456789ABC.
  - sig low the cycle after the handshake.
  - Byte 0x12 decodes as bits 0,1,0,0,1,0,0,0 with parity 0.
  - Last byte 0xBC has parity 1.
  - Each bit lasts 4 cycles; busy lasts 264 cycles; ready returns high at cycle 265.
- Back-to-back words: hold valid=1 with 48'hFFFFFFFFFFFF then 48'h000000000000.
  - Second handshake occurs on the first cycle ready=1.
  - Start bit of the second word directly follows the final stop bit.
  - Parity bits are 0 for every byte of both words.
- Valid while busy: pulse valid with new data mid-word -> no effect on sig stream; the original word is transmitted intact.
- Mid-frame reset: assert reset during the DATA state of byte 3 -> sig=1 the next cycle; ready=1 after release; a new word 48'hA5A5A5A5A5A5 then transmits correctly from byte 0.
- Config sweep (PARITY_EN=0, STOP_BITS=2): send 48'h0102030405FF -> frames are 11 bits with no parity and 2 stop bits; busy lasts 6*11*CLKS_PER_BIT cycles.

Source files
------------

// File: rtl/uart_word_tx.sv
// Serializes one DATA_LENGTH-bit word as MSB-byte-first UART frames on sig; start bit leads one cycle after the handshake.
// ready stays low from handshake until the final stop bit ends; valid is ignored in the meantime.
module uart_word_tx #(
  parameter int DATA_LENGTH  = 48,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_LENGTH-1:0] data,
  input  logic                   valid,
  output logic                   ready,
  output logic                   sig,
  output logic                   busy
);

  localparam int NBYTES = DATA_LENGTH / 8;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  generate
    if ((DATA_LENGTH % 8) != 0 || DATA_LENGTH < 8) begin : g_bad_len
      $error("uart_word_tx: DATA_LENGTH must be a non-zero multiple of 8");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_word_tx: CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_word_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_n;
  logic [BAUD_W-1:0]      baud_cnt, baud_n;
  logic [2:0]             bit_cnt, bit_n;
  logic [BYTE_W-1:0]      byte_cnt, byte_n;
  logic [DATA_LENGTH-1:0] shreg, shreg_n;
  logic                   sig_n, ready_n, busy_n;
  logic [7:0]             cur_byte;
  logic                   tick;

  assign cur_byte = shreg[DATA_LENGTH-1 -: 8];
  assign tick     = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      sig      <= 1'b1;
      ready    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      byte_cnt <= byte_n;
      shreg    <= shreg_n;
      sig      <= sig_n;
      ready    <= ready_n;
      busy     <= busy_n;
    end
  end

  // sig_n always carries the level of the bit that starts on the next edge.
  always_comb begin
    state_n = state;
    baud_n  = tick ? '0 : baud_cnt + 1'b1;
    bit_n   = bit_cnt;
    byte_n  = byte_cnt;
    shreg_n = shreg;
    sig_n   = sig;
    ready_n = 1'b0;
    busy_n  = 1'b1;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (valid && ready) begin
          shreg_n = data;
          byte_n  = '0;
          state_n = START;
          sig_n   = 1'b0;
        end else begin
          sig_n   = 1'b1;
          ready_n = 1'b1;
          busy_n  = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          bit_n   = '0;
          sig_n   = cur_byte[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == 3'd7) begin
            bit_n = '0;
            if (PARITY_EN != 0) begin
              state_n = PARITY;
              sig_n   = ^cur_byte;
            end else begin
              state_n = STOP;
              sig_n   = 1'b1;
            end
          end else begin
            bit_n = bit_cnt + 3'd1;
            sig_n = cur_byte[bit_cnt + 3'd1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_n = STOP;
          bit_n   = '0;
          sig_n   = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt == 3'(STOP_BITS - 1)) begin
            bit_n = '0;
            if (byte_cnt == BYTE_W'(NBYTES - 1)) begin
              state_n = IDLE;
              sig_n   = 1'b1;
              ready_n = 1'b1;
              busy_n  = 1'b0;
            end else begin
              state_n = START;
              byte_n  = byte_cnt + 1'b1;
              shreg_n = shreg << 8;
              sig_n   = 1'b0;
            end
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        sig_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: two instances (parity + 1 stop, no parity + 2 stops) checked against a frame-level line model.
module tb_uart_word_tx;
  localparam int CPB = 4;

  typedef struct {
    logic [47:0] w;
    logic [5:0]  par;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] data;
  logic        valid0, valid1;
  logic        ready0, ready1, sig0, sig1, busy0, busy1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  uart_word_tx #(.DATA_LENGTH(48), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .data(data), .valid(valid0),
    .ready(ready0), .sig(sig0), .busy(busy0)
  );

  uart_word_tx #(.DATA_LENGTH(48), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .data(data), .valid(valid1),
    .ready(ready1), .sig(sig1), .busy(busy1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected line level k cycles after the handshake edge, from frame layout alone.
  function automatic logic model_sig(input logic [47:0] w, input int pen, input int nstop, input int k);
    int idx, flen, by, pos;
    logic [7:0] b;
    idx  = k / CPB;
    flen = 10 + pen + nstop - 1;
    by   = idx / flen;
    pos  = idx % flen;
    b    = w[47 - 8*by -: 8];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pen != 0 && pos == 9) return ^b;
    return 1'b1;
  endfunction

  function automatic logic [5:0] model_par(input logic [47:0] w);
    logic [5:0] p;
    for (int by = 0; by < 6; by++) p[5-by] = ^w[47 - 8*by -: 8];
    return p;
  endfunction

  task automatic handshake(input bit sel, input logic [47:0] w, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    data = w;
    if (sel) valid1 = 1'b1; else valid0 = 1'b1;
    while (!(sel ? ready1 : ready0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("handshake_wait", 64'(n < 2000), 64'd1);
    @(posedge clk);
    #1;
    if (!hold) begin
      valid0 = 1'b0;
      valid1 = 1'b0;
    end
  endtask

  task automatic expect_word(input bit sel, input logic [47:0] w, input string name, input int poke_k,
                             output logic [5:0] par, output logic [47:0] dec);
    int pen, nstop, flen, dur, errs, berrs, idx, by, pos;
    logic s;
    pen   = sel ? 0 : 1;
    nstop = sel ? 2 : 1;
    flen  = 10 + pen + nstop - 1;
    dur   = 6 * flen * CPB;
    errs  = 0;
    berrs = 0;
    par   = '0;
    dec   = '0;
    for (int k = 0; k < dur; k++) begin
      @(negedge clk);
      if (poke_k >= 0 && k == poke_k) begin
        data = ~w;
        if (sel) valid1 = 1'b1; else valid0 = 1'b1;
      end
      if (poke_k >= 0 && k == poke_k + 1) begin
        valid0 = 1'b0;
        valid1 = 1'b0;
      end
      s = sel ? sig1 : sig0;
      if (s !== model_sig(w, pen, nstop, k)) errs++;
      if ((sel ? busy1 : busy0) !== 1'b1 || (sel ? ready1 : ready0) !== 1'b0) berrs++;
      if (k % CPB == CPB / 2) begin
        idx = k / CPB;
        by  = idx / flen;
        pos = idx % flen;
        if (pos >= 1 && pos <= 8) dec[40 - 8*by + pos - 1] = s;
        if (pen != 0 && pos == 9) par[5-by] = s;
      end
    end
    check({name, "_wave_errs"}, 64'(errs), 64'd0);
    check({name, "_busy_errs"}, 64'(berrs), 64'd0);
    check({name, "_decode"}, 64'(dec), 64'(w));
  endtask

  task automatic tail(input bit sel, input string name);
    @(negedge clk);
    check({name, "_end_rdy_busy_sig"}, sel ? {ready1, busy1, sig1} : {ready0, busy0, sig0}, 64'b101);
  endtask

  initial begin
    vec_t        tbl[4];
    logic [5:0]  par;
    logic [47:0] dec, w;

    tbl[0] = '{w: 48'h123456789ABC, par: 6'b010001};
    tbl[1] = '{w: 48'h018007FE3C81, par: 6'b111100};
    tbl[2] = '{w: 48'hDEADBEEF0001, par: 6'b010101};
    tbl[3] = '{w: 48'hA5A5A5A5A5A5, par: 6'b000000};

    // Reset held with valid asserted: nothing may be captured.
    reset  = 1'b1;
    valid0 = 1'b1;
    valid1 = 1'b1;
    data   = 48'hCAFE_F00D_BEEF;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold_sig_rdy_busy", {sig0, ready0, busy0}, 64'b100);
    end
    reset = 1'b0;
    @(negedge clk);
    check("release_rdy_busy_sig_0", {ready0, busy0, sig0}, 64'b101);
    check("release_rdy_busy_sig_1", {ready1, busy1, sig1}, 64'b101);
    valid0 = 1'b0;
    valid1 = 1'b0;

    for (int i = 0; i < 4; i++) begin
      handshake(0, tbl[i].w, 0);
      expect_word(0, tbl[i].w, $sformatf("tbl%0d", i), -1, par, dec);
      check($sformatf("tbl%0d_parity", i), 64'(par), 64'(tbl[i].par));
      tail(0, $sformatf("tbl%0d", i));
    end

    for (int i = 0; i < 3; i++) begin
      w = {$urandom, $urandom};
      handshake(0, w, 0);
      expect_word(0, w, $sformatf("rnd%0d", i), -1, par, dec);
      check($sformatf("rnd%0d_parity", i), 64'(par), 64'(model_par(w)));
      tail(0, $sformatf("rnd%0d", i));
    end

    // Back-to-back: valid held, second word accepted in the first ready cycle.
    handshake(0, 48'hFFFFFFFFFFFF, 1);
    data = 48'h000000000000;
    expect_word(0, 48'hFFFFFFFFFFFF, "b2b_w1", -1, par, dec);
    check("b2b_w1_parity", 64'(par), 64'd0);
    @(negedge clk);
    check("b2b_gap_rdy_sig_busy", {ready0, sig0, busy0}, 64'b110);
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    expect_word(0, 48'h000000000000, "b2b_w2", -1, par, dec);
    check("b2b_w2_parity", 64'(par), 64'd0);
    tail(0, "b2b_w2");

    handshake(0, 48'h5A3C0F96C3E1, 0);
    expect_word(0, 48'h5A3C0F96C3E1, "poke", 100, par, dec);
    tail(0, "poke");

    // Reset during byte 3 data bits.
    handshake(0, 48'h0F1E2D3C4B5A, 0);
    repeat ((3 * 11 + 3) * CPB + 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_sig_busy_rdy", {sig0, busy0, ready0}, 64'b100);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_release_rdy_busy_sig", {ready0, busy0, sig0}, 64'b101);
    handshake(0, 48'hA5A5A5A5A5A5, 0);
    expect_word(0, 48'hA5A5A5A5A5A5, "after_rst", -1, par, dec);
    check("after_rst_parity", 64'(par), 64'd0);
    tail(0, "after_rst");

    handshake(1, 48'h0102030405FF, 0);
    expect_word(1, 48'h0102030405FF, "cfg2", -1, par, dec);
    tail(1, "cfg2");
    for (int i = 0; i < 2; i++) begin
      w = {$urandom, $urandom};
      handshake(1, w, 0);
      expect_word(1, w, $sformatf("cfg2_rnd%0d", i), -1, par, dec);
      tail(1, $sformatf("cfg2_rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
